mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Clock and reset SHALL be: clk input 1 (single clock, rising edge); rst input 1 (reset is synchronous and active-high).
REQ-002 Pipeline-side ports SHALL be: req_valid in 1 (request strobe); req_we in 1 (1=store, 0=load); req_funct3 in 3 (RV32I width/sign code); req_addr in 32 (byte address); req_wdata in 32 (store data, LSB-aligned).
REQ-003 Pipeline-side outputs SHALL be: ready out 1 (accepts request); done out 1 (one-cycle completion pulse); err out 1 (misaligned or invalid, valid with done); rdata out 32 (load result, valid with done).
REQ-004 Memory-side ports SHALL be: mem_addr out 10 (word address); mem_we out 1; mem_din out 32; mem_dout in 32 (combinational read data of the addressed word).

Function
REQ-005 Word address SHALL be req_addr[11:2], registered at acceptance; byte lane SHALL be req_addr[1:0].
REQ-006 FSM states SHALL be IDLE, LOAD, STORE_RD, STORE_WR, RESP; ready SHALL be 1 only in IDLE.
REQ-007 A request SHALL be accepted when req_valid=1 in IDLE; req_valid in any other state SHALL be ignored, not queued.
REQ-008 From IDLE on acceptance: load->LOAD; SW->STORE_WR; SB/SH->STORE_RD; misaligned or invalid funct3->RESP with err=1.
REQ-009 Misaligned SHALL mean halfword with addr[0]=1 or word with addr[1:0]!=0; valid load funct3 = 000,001,010,100,101; valid store funct3 = 000,001,010.
REQ-010 LOAD SHALL last one cycle, capture mem_dout, extract lane, sign-extend (LB/LH) or zero-extend (LBU/LHU) into rdata, then go to RESP.
REQ-011 STORE_RD SHALL last one cycle, capture mem_dout, merge req_wdata byte/halfword into the selected lane(s), then go to STORE_WR.
REQ-012 STORE_WR SHALL assert mem_we=1 for exactly one cycle, with mem_din = merged word (SW: req_wdata unchanged), then go to RESP.
REQ-013 RESP SHALL assert done=1 for one cycle, then return to IDLE.
REQ-014 Latency from accept cycle T: load and SW done at T+2; SB/SH done at T+3; error done at T+1.
REQ-015 mem_we SHALL be 0 in every state except STORE_WR; mem_addr SHALL hold the registered word address from acceptance until IDLE.
REQ-016 rdata SHALL hold its value until the next load completes; on stores and errors rdata SHALL be 0.
REQ-017 Word 0 is the memory's input-port location; the unit SHALL not special-case any address.
REQ-018 On an error, no memory write SHALL occur.

Reset
REQ-019 With rst=1 at a clock edge the FSM SHALL enter IDLE; ready=1, done=0, err=0, rdata=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-020 Reset in STORE_RD or STORE_WR SHALL abort the store with no write in or after the reset cycle; no done pulse SHALL follow.

Structure
REQ-021 A shared package SHALL hold funct3 codes (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state encoding.
REQ-022 Lane extract/extend and lane merge SHALL be a combinational sub-module mem_lane_align; the FSM and registers stay in mem_access_unit.

Verification
REQ-023 Word 4 = 0x8899AABB; LB at 0x011 -> done at T+2, rdata=0xFFFFFFAA, err=0; LBU at 0x011 -> rdata=0x000000AA.
REQ-024 Word 4 = 0x8899AABB; SH 0x1234 at 0x012 -> mem_we at T+2 only, mem_addr=4, mem_din=0x1234AABB, done at T+3.
REQ-025 SW 0xDEADBEEF at 0x004 -> mem_we at T+1, mem_addr=1, mem_din=0xDEADBEEF; LW at 0x004 -> rdata=0xDEADBEEF.
REQ-026 LW at 0x006 -> done and err=1 at T+1, mem_we never 1, rdata=0.
REQ-027 SB accepted, rst=1 in the STORE_RD cycle -> mem_we stays 0, no done, ready=1 the next cycle.
REQ-028 req_valid held high over a load -> exactly one done; a second request is accepted only in the following IDLE cycle.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
// Holds the RV32I load/store width codes (funct3), the FSM state encoding
// and a helper that classifies a request as misaligned or unsupported.
package mem_access_unit_pkg;

  // Load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes (share encodings with the signed loads)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    STORE_RD = 3'd2,
    STORE_WR = 3'd3,
    RESP     = 3'd4
  } state_e;

  // Returns 1 when the request must be answered with an error instead of
  // touching memory: unknown width code, or an address not aligned to it.
  function automatic logic req_is_bad(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    if (we) begin
      case (funct3)
        F3_SB:   bad = 1'b0;
        F3_SH:   bad = lane[0];
        F3_SW:   bad = (lane != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: bad = 1'b0;
        F3_LH, F3_LHU: bad = lane[0];
        F3_LW:         bad = (lane != 2'b00);
        default:       bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for the memory access unit.
//   funct3     : width/sign code of the current access
//   lane       : byte offset within the word (addr[1:0])
//   mem_word   : word read from memory
//   wdata      : store data, LSB-aligned
//   load_data  : selected lane(s), sign- or zero-extended to 32 bits
//   store_word : mem_word with the store data merged into the selected lane(s)
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  word_bytes [4];
  logic [3:0]  lane_hit;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_bytes[gi] = mem_word[8*gi +: 8];

      // A halfword store covers both bytes of the half chosen by lane[1].
      assign lane_hit[gi] = (funct3 == F3_SW)
                         || ((funct3 == F3_SB) && (lane == 2'(gi)))
                         || ((funct3 == F3_SH) && (lane[1] == (gi >= 2)));

      // Byte stores replicate wdata[7:0]; halfword stores take the low or
      // high byte of wdata[15:0] depending on the lane's position in the half.
      assign store_word[8*gi +: 8] = !lane_hit[gi]        ? word_bytes[gi]
                                   : (funct3 == F3_SB)    ? wdata[7:0]
                                   : (funct3 == F3_SH)    ? wdata[8*(gi%2) +: 8]
                                   :                        wdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = word_bytes[lane];
  assign half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_data = mem_word;
      F3_LBU:  load_data = {24'd0, byte_sel};
      F3_LHU:  load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between an RV32I pipeline and a single-port word memory
// with combinational read data.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/we/funct3/addr/wdata: request from the pipeline
//   ready                         : unit is idle and will accept a request
//   done, err, rdata              : one-cycle completion pulse with status/data
//   mem_addr, mem_we, mem_din     : memory word address, write strobe, data
//   mem_dout                      : memory read data for mem_addr
// Sub-word stores are read-modify-write: read the word, merge, write back.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [9:0]  mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  state_e      state_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  lane_reg;
  logic [31:0] wdata_reg;
  logic [9:0]  mem_addr_reg;
  logic [31:0] mem_din_reg;
  logic        mem_we_reg;
  logic        ready_reg;
  logic        done_reg;
  logic        err_reg;
  logic [31:0] rdata_reg;

  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        req_bad;

  // Only the low 12 address bits reach the 1K-word memory.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, req_addr[31:12]};

  assign req_bad = req_is_bad(req_we, req_funct3, req_addr[1:0]);

  mem_lane_align u_lane_align (
    .funct3     (funct3_reg),
    .lane       (lane_reg),
    .mem_word   (mem_dout),
    .wdata      (wdata_reg),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      funct3_reg   <= '0;
      lane_reg     <= '0;
      wdata_reg    <= '0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
      mem_we_reg   <= 1'b0;
      ready_reg    <= 1'b1;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      done_reg   <= 1'b0;
      mem_we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            funct3_reg   <= req_funct3;
            lane_reg     <= req_addr[1:0];
            wdata_reg    <= req_wdata;
            mem_addr_reg <= req_addr[11:2];
            ready_reg    <= 1'b0;
            if (req_bad) begin
              state_reg <= RESP;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
              rdata_reg <= '0;
            end else if (!req_we) begin
              state_reg <= LOAD;
            end else if (req_funct3 == F3_SW) begin
              // Full-word store needs no read, write straight away.
              state_reg   <= STORE_WR;
              mem_we_reg  <= 1'b1;
              mem_din_reg <= req_wdata;
            end else begin
              state_reg <= STORE_RD;
            end
          end
        end
        LOAD: begin
          rdata_reg <= load_data;
          err_reg   <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= RESP;
        end
        STORE_RD: begin
          mem_din_reg <= store_word;
          mem_we_reg  <= 1'b1;
          state_reg   <= STORE_WR;
        end
        STORE_WR: begin
          rdata_reg <= '0;
          err_reg   <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= RESP;
        end
        RESP: begin
          err_reg   <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ready    = ready_reg;
  assign done     = done_reg;
  assign err      = err_reg;
  assign rdata    = rdata_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_din  = mem_din_reg;
  // A reset arriving during the write cycle suppresses that write too.
  assign mem_we   = mem_we_reg & ~rst;

endmodule
